// File: rtl/branch_ctrl.sv
// Branch and run-control unit: decodes BRR/JMP/HALT, drives the PC branch controls,
// and owns the flag register, absolute-target LUT and the Start/Done run handshake.
module branch_ctrl #(
    parameter int A     = 10,
    parameter int LUT_N = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [8:0]   Inst,
    input  logic [A-1:0] PC,
    input  logic         ALU_flag,
    input  logic         FlagWrEn,
    input  logic         LutWrEn,
    input  logic [4:0]   LutWrAddr,
    input  logic [A-1:0] LutWrData,
    output logic         BranchAbsEn,
    output logic         BranchRelEn,
    output logic [A-1:0] AbsTarget,
    output logic [5:0]   RelTarget,
    output logic         BrFlag,
    output logic         Done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_ARMED  = 2'd3;

    logic [1:0]   r_state;
    logic         r_start_d;
    logic         r_flag;
    logic         r_done;
    logic [A-1:0] r_halt_pc;
    logic [A-1:0] r_lut [LUT_N];

    logic w_is_brr;
    logic w_is_jmp;
    logic w_is_halt;
    logic w_start_rise;
    logic w_start_fall;

    assign w_is_brr     = (Inst[8:6] == 3'b110);
    assign w_is_jmp     = (Inst[8:6] == 3'b111) && !Inst[5];
    assign w_is_halt    = (Inst == 9'h1FF);
    assign w_start_rise = Start && !r_start_d;
    assign w_start_fall = !Start && r_start_d;

    // Run-control FSM plus the Done/HaltPC bookkeeping tied to its transitions.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_start_d <= 1'b0;
            r_done    <= 1'b0;
            r_halt_pc <= '0;
        end else begin
            r_start_d <= Start;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_fall) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_is_halt) begin
                        r_state   <= ST_HALTED;
                        r_halt_pc <= PC;
                        r_done    <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (w_start_rise) begin
                        r_state <= ST_ARMED;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    if (w_start_fall) r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_flag <= 1'b1;
        end else if (FlagWrEn) begin
            r_flag <= ALU_flag;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LUT_N; i++) r_lut[i] <= '0;
        end else if (LutWrEn) begin
            r_lut[LutWrAddr] <= LutWrData;
        end
    end

    // BrFlag=0 means "take the branch" at the PC, so parks and jumps drive it low.
    always_comb begin
        BranchAbsEn = 1'b0;
        BranchRelEn = 1'b0;
        AbsTarget   = '0;
        BrFlag      = 1'b1;
        case (r_state)
            ST_RUN: begin
                if (w_is_halt) begin
                    BranchAbsEn = 1'b1;
                    AbsTarget   = PC;
                    BrFlag      = 1'b0;
                end else if (w_is_jmp) begin
                    BranchAbsEn = 1'b1;
                    AbsTarget   = r_lut[Inst[4:0]];
                    BrFlag      = 1'b0;
                end else if (w_is_brr) begin
                    BranchRelEn = 1'b1;
                    BrFlag      = r_flag;
                end
            end
            ST_HALTED, ST_ARMED: begin
                BranchAbsEn = 1'b1;
                AbsTarget   = r_halt_pc;
                BrFlag      = 1'b0;
            end
            default: ;
        endcase
    end

    assign RelTarget = Inst[5:0];
    assign Done      = r_done;

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized self-checking bench for branch_ctrl against a cycle-level behavioural model.
module tb_branch_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, Start, ALU_flag, FlagWrEn, LutWrEn;
    logic [8:0] Inst;
    logic [9:0] PC, LutWrData;
    logic [4:0] LutWrAddr;
    logic       BranchAbsEn, BranchRelEn, BrFlag, Done;
    logic [9:0] AbsTarget;
    logic [5:0] RelTarget;

    int checks = 0;
    int errors = 0;

    branch_ctrl #(.A(10), .LUT_N(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Inst(Inst), .PC(PC),
        .ALU_flag(ALU_flag), .FlagWrEn(FlagWrEn), .LutWrEn(LutWrEn),
        .LutWrAddr(LutWrAddr), .LutWrData(LutWrData),
        .BranchAbsEn(BranchAbsEn), .BranchRelEn(BranchRelEn),
        .AbsTarget(AbsTarget), .RelTarget(RelTarget), .BrFlag(BrFlag), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Reference model: mode is one of "idle", "run", "halted", "armed".
    string      m_mode;
    logic       m_flag, m_done, m_prev_start;
    logic [9:0] m_halt_pc;
    logic [9:0] m_lut [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_compare();
        logic       e_abs, e_rel, e_fl;
        logic [9:0] e_tgt;
        e_abs = 0; e_rel = 0; e_fl = 1; e_tgt = 0;
        if (m_mode == "run") begin
            if (Inst == 9'h1FF) begin
                e_abs = 1; e_tgt = PC; e_fl = 0;
            end else if (Inst[8:6] == 3'd6) begin
                e_rel = 1; e_fl = m_flag;
            end else if (Inst[8:5] == 4'b1110) begin
                e_abs = 1; e_tgt = m_lut[Inst[4:0]]; e_fl = 0;
            end
        end else if (m_mode == "halted" || m_mode == "armed") begin
            e_abs = 1; e_tgt = m_halt_pc; e_fl = 0;
        end
        chk("abs_en", 32'(BranchAbsEn), 32'(e_abs));
        chk("rel_en", 32'(BranchRelEn), 32'(e_rel));
        chk("abs_tgt", 32'(AbsTarget), 32'(e_tgt));
        chk("rel_tgt", 32'(RelTarget), 32'(Inst % 64));
        chk("brflag", 32'(BrFlag), 32'(e_fl));
        chk("done", 32'(Done), 32'(m_done));
        chk("exclusive", 32'(BranchAbsEn & BranchRelEn), 32'd0);
    endtask

    task automatic model_update();
        logic rise, fall;
        if (Reset) begin
            m_mode = "idle"; m_flag = 1; m_done = 0; m_halt_pc = 0; m_prev_start = 0;
            for (int i = 0; i < 32; i++) m_lut[i] = 0;
        end else begin
            rise = Start && !m_prev_start;
            fall = !Start && m_prev_start;
            if (m_mode == "idle" && fall) m_mode = "run";
            else if (m_mode == "run" && Inst == 9'h1FF) begin
                m_mode = "halted"; m_halt_pc = PC; m_done = 1;
            end else if (m_mode == "halted" && rise) begin
                m_mode = "armed"; m_done = 0;
            end else if (m_mode == "armed" && fall) m_mode = "run";
            if (FlagWrEn) m_flag = ALU_flag;
            if (LutWrEn) m_lut[LutWrAddr] = LutWrData;
            m_prev_start = Start;
        end
    endtask

    // Inputs are set at posedge+1; compare at negedge, advance model at posedge.
    task automatic step();
        @(negedge Clk);
        model_compare();
        @(posedge Clk);
        model_update();
        #1;
    endtask

    initial begin
        Reset = 1; Start = 0; Inst = 0; PC = 0; ALU_flag = 0; FlagWrEn = 0;
        LutWrEn = 0; LutWrAddr = 0; LutWrData = 0;
        m_mode = "idle"; m_flag = 1; m_done = 0; m_halt_pc = 0; m_prev_start = 0;
        for (int i = 0; i < 32; i++) m_lut[i] = 0;
        @(posedge Clk); model_update(); #1;
        step();
        Reset = 0;

        // Idle: JMP without Start does nothing
        Inst = 9'h1C5; #1;
        chk("idle_abs", 32'(BranchAbsEn), 32'd0);
        chk("idle_done", 32'(Done), 32'd0);
        step();

        // LUT write then Start pulse, JMP index 5
        LutWrEn = 1; LutWrAddr = 5; LutWrData = 10'd300; Inst = 0; step();
        LutWrEn = 0; Start = 1; step();
        Start = 0; step();
        Inst = 9'h1C5; #1;
        chk("jmp_abs", 32'(BranchAbsEn), 32'd1);
        chk("jmp_tgt", 32'(AbsTarget), 32'd300);
        chk("jmp_flag", 32'(BrFlag), 32'd0);
        step();

        // BRR with flag 0 then 1, and same-cycle write uses old flag
        Inst = 0; FlagWrEn = 1; ALU_flag = 0; step();
        FlagWrEn = 0; Inst = 9'h183; #1;
        chk("brr_rel", 32'(BranchRelEn), 32'd1);
        chk("brr_off", 32'(RelTarget), 32'd3);
        chk("brr_flag0", 32'(BrFlag), 32'd0);
        FlagWrEn = 1; ALU_flag = 1; #1;
        chk("brr_same_cycle", 32'(BrFlag), 32'd0);
        step();
        FlagWrEn = 0; #1;
        chk("brr_flag1", 32'(BrFlag), 32'd1);
        step();

        // HALT with PC=57
        PC = 10'd57; Inst = 9'h1FF; #1;
        chk("halt_tgt", 32'(AbsTarget), 32'd57);
        chk("halt_done_pre", 32'(Done), 32'd0);
        step();
        chk("halt_done", 32'(Done), 32'd1);
        Inst = 9'h1C5; PC = 10'd99; #1;
        chk("park_tgt", 32'(AbsTarget), 32'd57);
        step();

        // Restart: Start held 3 cycles, then released
        Start = 1; step();
        chk("done_clear", 32'(Done), 32'd0);
        step(); step();
        Start = 0; step();
        Inst = 9'h1C5; #1;
        chk("rerun_tgt", 32'(AbsTarget), 32'd300);
        step();

        // Reset in RUN clears everything
        Reset = 1; step();
        Reset = 0; Inst = 9'h183; #1;
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_rel", 32'(BranchRelEn), 32'd0);
        step();
        Start = 1; step();
        Start = 0; step();
        Inst = 9'h1C5; #1;
        chk("rst_lut_abs", 32'(BranchAbsEn), 32'd1);
        chk("rst_lut_tgt", 32'(AbsTarget), 32'd0);
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = $urandom_range(99);
            if (sel < 5)       Inst = 9'h1FF;
            else if (sel < 35) Inst = {3'b110, 6'($urandom)};
            else if (sel < 65) Inst = {4'b1110, 5'($urandom)};
            else               Inst = 9'($urandom);
            PC        = 10'($urandom);
            ALU_flag  = 1'($urandom);
            FlagWrEn  = ($urandom_range(3) == 0);
            LutWrEn   = ($urandom_range(3) == 0);
            LutWrAddr = 5'($urandom);
            LutWrData = 10'($urandom);
            if ($urandom_range(7) == 0) Start = ~Start;
            Reset     = ($urandom_range(199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=0 expected=1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Single-cycle branch and run-control unit between instruction memory and the program counter. Decodes the current 9-bit instruction and drives the PC's absolute/relative branch controls, target values and branch-condition flag. Owns the branch flag register, a 32-entry absolute-target lookup table (LUT), and the program run/halt/Done handshake with the test bench.

## Interface
- A, 10: instruction-address width; matches the PC width.
- LUT_N, 32: number of absolute-target LUT entries; index is Inst[4:0].
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  test-bench program request; a full pulse is high then low.
- Inst  in  9  current instruction from instruction memory.
- PC  in  A  current program-counter value.
- ALU_flag  in  1  raw flag from the ALU.
- FlagWrEn  in  1  capture ALU_flag into the flag register this cycle.
- LutWrEn  in  1  write one LUT entry.
- LutWrAddr  in  5  LUT write index.
- LutWrData  in  A  LUT write data.
- BranchAbsEn  out  1  to PC: absolute jump.
- BranchRelEn  out  1  to PC: relative jump.
- AbsTarget  out  A  to PC: absolute target.
- RelTarget  out  6  to PC: relative offset, Inst[5:0].
- BrFlag  out  1  to PC's flag input; the PC branches only when BrFlag=0.
- Done  out  1  program finished; held until the next Start rise.

## Operation
- Decode, combinational on Inst:
  - BRR: Inst[8:6]=3'b110.
  - JMP: Inst[8:6]=3'b111 and Inst[5]=0.
  - HALT: Inst[8:0]=9'h1FF.
  - Any other pattern is non-branch.
- Flag register:
  - Reset value is 1.
  - On FlagWrEn, loads ALU_flag at the posedge.
- LUT:
  - LUT_N×A registers, all cleared to 0 on Reset.
  - LutWrEn writes LutWrData at LutWrAddr at the posedge.
  - Readback is combinational, so a write becomes visible the next cycle.
- FSM states:
  - IDLE (reset state) -> RUN on a Start falling edge. Edge detection uses a registered copy start_r, which resets to 0.
  - RUN -> HALTED when HALT is decoded in RUN; Done goes high the next cycle.
  - HALTED -> ARMED on a Start rising edge; Done clears the next cycle.
  - ARMED -> RUN on a Start falling edge.
  - A falling edge in HALTED without a preceding rise is ignored.
- Outputs in RUN:
  - BRR: BranchRelEn=1, BrFlag=flag register.
  - JMP: BranchAbsEn=1, AbsTarget=LUT[Inst[4:0]], BrFlag=0, so the jump is unconditional.
  - HALT: BranchAbsEn=1, AbsTarget=PC, BrFlag=0, so the PC parks.
  - Non-branch: both enables 0, BrFlag=1.
- Outputs in HALTED and ARMED:
  - Forced park: BranchAbsEn=1, AbsTarget=HaltPC register, BrFlag=0.
  - HaltPC is captured from PC on the RUN->HALTED transition and reset to 0.
- Outputs in IDLE:
  - Both enables 0, BrFlag=1. The PC self-holds before the first Start.
- Fixed rules:
  - BranchAbsEn and BranchRelEn are never high together.
  - RelTarget=Inst[5:0] always, zero-extended by the PC.
  - AbsTarget=0 whenever BranchAbsEn=0.

## Timing
- Single-cycle datapath: enables, targets and BrFlag are combinational from Inst, state, flag register and LUT in the same cycle.
- FlagWrEn on cycle n affects a BRR on cycle n+1 or later. A FlagWrEn and BRR in the same cycle use the old flag.
- Done is registered:
  - Rises 1 cycle after HALT is decoded.
  - Falls 1 cycle after the Start rising edge is detected.
- Start fall to RUN: 1 cycle. The instruction present in that RUN cycle is the first one decoded.
- Reset mid-operation: the next cycle shows IDLE, Done=0, flag=1, LUT cleared, HaltPC=0.
- Reset has priority over every write, including LutWrEn, FlagWrEn and FSM transitions.
- Simultaneous LutWrEn and a JMP on the same index: the JMP uses the old entry.
- Start held high across many cycles counts as one edge. A Start pulse in RUN is ignored by the FSM.

## Test plan
- Reset, then Inst=9'h1C5 with no Start -> BranchAbsEn=0, Done=0, state IDLE.
- Write LUT[5]=10'd300, Start pulse, then Inst=9'h1C5 in RUN -> BranchAbsEn=1, AbsTarget=300, BrFlag=0.
- FlagWrEn with ALU_flag=0, then Inst=9'h183 -> BranchRelEn=1, RelTarget=3, BrFlag=0. Repeat with ALU_flag=1 -> BrFlag=1, so no branch.
- PC=57, Inst=9'h1FF in RUN -> BranchAbsEn=1, AbsTarget=57 that cycle; Done=1 next cycle; AbsTarget stays 57 while Inst changes.
- From HALTED, Start high for 3 cycles -> Done=0 one cycle after the rise. Start low -> RUN one cycle later, and a JMP is decoded normally.
- Reset asserted in RUN with LUT[5]=300 -> the next cycle gives Done=0 and a BRR-free IDLE, and a later JMP index 5 after Start gives AbsTarget=0.
